// File: rtl/led_pkg.sv
// Shared constants for the LED sequencer: mode encodings, seed patterns, default divider.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  // One step per second at 50 MHz.
  localparam int unsigned DIV_DEFAULT = 50000000;

  localparam logic [7:0] SEED_BLINK = 8'hFF;
  localparam logic [7:0] SEED_OTHER = 8'h01;

  // BOUNCE direction flag encoding.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Pattern loaded when a mode is (re)applied.
  function automatic logic [7:0] seed_of(mode_e m);
    return (m == MODE_BLINK) ? SEED_BLINK : SEED_OTHER;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Request/status bundle between a mode controller and the LED sequencer.
interface led_seq_ctrl_if;
  logic [1:0] mode_req;
  logic       mode_valid;
  logic       pause;
  logic [7:0] LEDG;
  logic [1:0] mode_o;
  logic       pending_o;

  modport master (
    output mode_req, mode_valid, pause,
    input  LEDG, mode_o, pending_o
  );

  modport slave (
    input  mode_req, mode_valid, pause,
    output LEDG, mode_o, pending_o
  );
endinterface

// File: rtl/tick_gen.sv
// Step divider: counts 0..DIV-1 and flags the last count as a one-cycle tick.
module tick_gen #(
  parameter int unsigned DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic pause,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Tick only while running; a paused counter never fires.
  assign tick = !pause && (cnt_q == LAST);

  // Advance and wrap, or hold while paused.
  always_comb begin
    cnt_d = cnt_q;
    if (!pause) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Count register; reset discards any partial step.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: mode/pending bookkeeping and per-step pattern update.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input logic           CLOCK_50,
  input logic           RST_N,
  led_seq_ctrl_if.slave bus
);

  logic       tick;
  logic [7:0] led_q, led_d;
  mode_e      mode_q, mode_d;
  mode_e      pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       dir_q, dir_d;
  mode_e      req;

  assign req = mode_e'(bus.mode_req);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .pause    (bus.pause),
    .tick     (tick)
  );

  // Next-state: a tick applies a request (same-cycle request first, then the
  // stored one) or advances the pattern; off-tick requests only update pending.
  always_comb begin
    led_d      = led_q;
    mode_d     = mode_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    dir_d      = dir_q;
    if (tick) begin
      pend_vld_d = 1'b0;
      if (bus.mode_valid || pend_vld_q) begin
        mode_d = bus.mode_valid ? req : pend_q;
        led_d  = seed_of(mode_d);
        dir_d  = DIR_LEFT;
      end else begin
        unique case (mode_q)
          MODE_BLINK: led_d = ~led_q;
          MODE_SHIFT: led_d = {led_q[6:0], led_q[7]};
          MODE_BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              if (led_q == 8'h80) begin
                led_d = 8'h40;
                dir_d = DIR_RIGHT;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q == 8'h01) begin
                led_d = 8'h02;
                dir_d = DIR_LEFT;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          MODE_FILL: begin
            if (led_q == 8'hFF)      led_d = 8'h00;
            else if (led_q == 8'h00) led_d = 8'h01;
            else                     led_d = {led_q[6:0], 1'b1};
          end
          default: led_d = led_q;
        endcase
      end
    end else if (bus.mode_valid) begin
      // Last request wins until the next tick.
      pend_d     = req;
      pend_vld_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to the idle BLINK state.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      led_q      <= 8'h00;
      mode_q     <= MODE_BLINK;
      pend_q     <= MODE_BLINK;
      pend_vld_q <= 1'b0;
      dir_q      <= DIR_LEFT;
    end else begin
      led_q      <= led_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      dir_q      <= dir_d;
    end
  end

  assign bus.LEDG      = led_q;
  assign bus.mode_o    = mode_q;
  assign bus.pending_o = pend_vld_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl at DIV=4: directed scenarios with literal checks plus a
// phase-based reference model compared on every falling clock edge.
module tb_led_seq_ctrl;

  localparam int DIV = 4;

  logic CLOCK_50 = 1'b0;
  logic RST_N    = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  led_seq_ctrl_if bus ();

  led_seq_ctrl #(.DIV(DIV)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %02h want %02h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each mode is a cycle of positions; LEDG is a pure function of (mode, phase).
  int m_cnt, m_mode, m_ph, m_pend;

  function automatic int period_of(int md);
    case (md)
      0: return 2;
      1: return 8;
      2: return 14;
      default: return 9;
    endcase
  endfunction

  function automatic int seed_ph(int md);
    return (md == 0 || md == 3) ? 1 : 0;
  endfunction

  function automatic logic [7:0] led_of(int md, int ph);
    logic [7:0] one;
    one = 8'h01;
    case (md)
      0: return (ph % 2 == 1) ? 8'hFF : 8'h00;
      1: return one << ph;
      2: return (ph <= 7) ? (one << ph) : (one << (14 - ph));
      default: return 8'((1 << ph) - 1);
    endcase
  endfunction

  function automatic void model_next(input int cnt, md, ph, pend,
                                     input logic mv, input logic [1:0] rq, input logic ps,
                                     output int ncnt, nmd, nph, npend);
    logic tk;
    tk    = !ps && (cnt == DIV - 1);
    ncnt  = ps ? cnt : (cnt + 1) % DIV;
    nmd   = md;
    nph   = ph;
    npend = pend;
    if (tk) begin
      if (mv || pend >= 0) begin
        nmd = mv ? int'(rq) : pend;
        nph = seed_ph(nmd);
      end else begin
        nph = (ph + 1) % period_of(md);
      end
      npend = -1;
    end else if (mv) begin
      npend = int'(rq);
    end
  endfunction

  always @(posedge CLOCK_50 or negedge RST_N) begin
    int c, md, ph, pd;
    if (!RST_N) begin
      m_cnt  <= 0;
      m_mode <= 0;
      m_ph   <= 0;
      m_pend <= -1;
    end else begin
      model_next(m_cnt, m_mode, m_ph, m_pend, bus.mode_valid, bus.mode_req, bus.pause,
                 c, md, ph, pd);
      m_cnt  <= c;
      m_mode <= md;
      m_ph   <= ph;
      m_pend <= pd;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge CLOCK_50) begin
    chk("cyc_ledg",    bus.LEDG,             led_of(m_mode, m_ph));
    chk("cyc_mode",    8'(bus.mode_o),       8'(m_mode));
    chk("cyc_pending", 8'(bus.pending_o),    8'(m_pend >= 0));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Issue a request one cycle after a tick; it lands on the following tick.
  task automatic req(logic [1:0] m);
    step(1);
    bus.mode_req = m; bus.mode_valid = 1'b1;
    step(1);
    bus.mode_valid = 1'b0;
    step(2);
  endtask

  logic [7:0] bounce_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] fill_exp [9] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    bus.mode_req = 2'd0; bus.mode_valid = 1'b0; bus.pause = 1'b0;
    #1 RST_N = 1'b0;
    step(2);
    chk("rst_ledg", bus.LEDG, 8'h00);
    chk("rst_mode", 8'(bus.mode_o), 8'h00);
    chk("rst_pend", 8'(bus.pending_o), 8'h00);
    #2 RST_N = 1'b1;

    // Idle BLINK after release.
    step(3);  chk("blink_pre", bus.LEDG, 8'h00);
    step(1);  chk("blink_t1",  bus.LEDG, 8'hFF);
    step(4);  chk("blink_t2",  bus.LEDG, 8'h00);
    step(4);  chk("blink_t3",  bus.LEDG, 8'hFF);
    chk("blink_mode", 8'(bus.mode_o), 8'h00);

    // SHIFT request with pending visible one cycle later.
    step(1);
    bus.mode_req = 2'd1; bus.mode_valid = 1'b1;
    step(1);
    bus.mode_valid = 1'b0;
    chk("shift_pend", 8'(bus.pending_o), 8'h01);
    step(2);
    chk("shift_seed", bus.LEDG, 8'h01);
    chk("shift_pclr", 8'(bus.pending_o), 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step(4);
      e = 8'h01 << (i % 8);
      chk("shift_step", bus.LEDG, e);
    end

    // BOUNCE across both reversals.
    req(2'd2);
    chk("bounce_seed", bus.LEDG, 8'h01);
    for (int i = 0; i < 15; i++) begin
      step(4);
      chk("bounce_step", bus.LEDG, bounce_exp[i]);
    end

    // FILL including the FF->00->01 wrap.
    req(2'd3);
    chk("fill_seed", bus.LEDG, 8'h01);
    for (int i = 0; i < 9; i++) begin
      step(4);
      chk("fill_step", bus.LEDG, fill_exp[i]);
    end

    // Re-request of the active mode re-seeds.
    step(4);  chk("fill_adv", bus.LEDG, 8'h03);
    req(2'd3);
    chk("reseed", bus.LEDG, 8'h01);

    // Request coinciding with the tick applies in the same edge.
    step(3);
    bus.mode_req = 2'd0; bus.mode_valid = 1'b1;
    step(1);
    bus.mode_valid = 1'b0;
    chk("byp_mode", 8'(bus.mode_o), 8'h00);
    chk("byp_ledg", bus.LEDG, 8'hFF);
    chk("byp_pend", 8'(bus.pending_o), 8'h00);

    // Two requests between ticks: last one wins.
    step(1);
    bus.mode_req = 2'd2; bus.mode_valid = 1'b1;
    step(1);
    bus.mode_req = 2'd3;
    step(1);
    bus.mode_valid = 1'b0;
    step(1);
    chk("last_mode", 8'(bus.mode_o), 8'h03);
    chk("last_ledg", bus.LEDG, 8'h01);

    // Pause mid-step with a request accepted while paused.
    step(2);
    bus.pause = 1'b1;
    step(1);
    bus.mode_req = 2'd1; bus.mode_valid = 1'b1;
    step(1);
    bus.mode_valid = 1'b0;
    step(8);
    chk("pause_ledg", bus.LEDG, 8'h01);
    chk("pause_mode", 8'(bus.mode_o), 8'h03);
    chk("pause_pend", 8'(bus.pending_o), 8'h01);
    bus.pause = 1'b0;
    step(1);
    chk("resume_hold", 8'(bus.mode_o), 8'h03);
    step(1);
    chk("resume_mode", 8'(bus.mode_o), 8'h01);
    chk("resume_pend", 8'(bus.pending_o), 8'h00);
    step(4);
    chk("resume_shift", bus.LEDG, 8'h02);

    // Reset mid-step with a pending request outstanding.
    step(1);
    bus.mode_req = 2'd2; bus.mode_valid = 1'b1;
    step(1);
    bus.mode_valid = 1'b0;
    chk("prerst_pend", 8'(bus.pending_o), 8'h01);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_ledg", bus.LEDG, 8'h00);
    chk("arst_mode", 8'(bus.mode_o), 8'h00);
    chk("arst_pend", 8'(bus.pending_o), 8'h00);
    @(posedge CLOCK_50);
    #3 RST_N = 1'b1;
    step(3);
    chk("post_pre", bus.LEDG, 8'h00);
    step(1);
    chk("post_t1", bus.LEDG, 8'hFF);
    chk("post_mode", 8'(bus.mode_o), 8'h00);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter DIV, default 50000000, is the number of CLOCK_50 cycles per sequencer step (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 CLOCK_50  input  1  single system clock; all state is updated on its rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 mode_req  input  2  requested pattern: 0 BLINK, 1 SHIFT, 2 BOUNCE, 3 FILL.
REQ-005 mode_valid  input  1  one-cycle strobe; mode_req is sampled on the same cycle.
REQ-006 pause  input  1  while high, the step counter and the LED pattern freeze.
REQ-007 LEDG  output  8  registered LED pattern.
REQ-008 mode_o  output  2  currently active pattern.
REQ-009 pending_o  output  1  high while an accepted mode request waits for the next step.

Function
REQ-010 The sub-module tick_gen shall count 0..DIV-1, wrap to 0, and assert tick for exactly one cycle when the count equals DIV-1.
REQ-011 When pause is high, tick_gen shall hold its count and shall not assert tick.
REQ-012 When mode_valid is high, mode_req shall be stored in the pending register and pending_o shall be set on the next edge; a later request shall overwrite an unapplied one (last request wins).
REQ-013 On a tick with a pending request, the following shall happen on that edge: mode_o takes the pending value, pending_o clears, and LEDG loads the seed for the new mode (BLINK 8'hFF; SHIFT, BOUNCE, FILL 8'h01); BOUNCE direction is set to left.
REQ-014 If mode_valid and tick coincide, that cycle's mode_req shall be applied at that tick (bypass), and pending_o shall remain 0.
REQ-015 A request for the already-active mode shall re-seed the pattern at the next tick.
REQ-016 On a tick with no pending request, BLINK shall set LEDG <= ~LEDG.
REQ-017 On such a tick, SHIFT shall rotate left: LEDG <= {LEDG[6:0], LEDG[7]}.
REQ-018 On such a tick, BOUNCE shall shift one position in the current direction; at 8'h80 the next value shall be 8'h40 with direction right, and at 8'h01 with direction right the next value shall be 8'h02 with direction left.
REQ-019 On such a tick, FILL shall set LEDG <= {LEDG[6:0], 1'b1}, except that 8'hFF shall go to 8'h00, and 8'h00 shall go to 8'h01.
REQ-020 LEDG and mode_o shall change only on tick edges; between ticks they shall hold.
REQ-021 mode_valid shall be accepted while pause is high; it shall be applied at the first tick after pause falls.
REQ-022 Latency from a tick to the LEDG update shall be 0 cycles (same edge); latency from mode_valid to pending_o shall be 1 cycle.

Reset
REQ-023 While RST_N is low, the following shall hold immediately and independently of the clock: LEDG = 8'h00, mode_o = BLINK, pending_o = 0, tick_gen count = 0, BOUNCE direction = left.
REQ-024 Reset asserted mid-step shall discard the partial count and any pending request.
REQ-025 After RST_N rises, the first tick shall occur after DIV rising edges; in BLINK mode, the first LEDG value after that tick shall be 8'hFF.

Structure
REQ-026 Mode encodings (BLINK/SHIFT/BOUNCE/FILL), the seed constants and the default DIV shall live in the shared package led_pkg.
REQ-027 The divider shall be the single sub-module tick_gen (ports CLOCK_50, RST_N, pause, tick; parameter DIV); the counter width shall be derived from DIV.
REQ-028 led_seq_ctrl shall hold the pattern logic, the mode/pending registers and the direction flag; no latches and no combinational paths from inputs to outputs.

Verification (DIV=4)
REQ-029 Reset release, no requests -> ticks on cycles 4, 8, 12; LEDG = 00, FF, 00, FF; mode_o = 0 throughout.
REQ-030 mode_valid with mode_req=1 at cycle 1 -> pending_o = 1 at cycle 2; at the cycle-4 tick LEDG = 01, pending_o = 0; subsequent ticks give 02, 04, …, 80, 01.
REQ-031 Mode BOUNCE for 16 ticks -> LEDG = 01, 02, …, 80, 40, 20, …, 01, 02; the direction reverses exactly at 80 and at 01.
REQ-032 Mode FILL -> LEDG = 01, 03, 07, …, FF, 00, 01 across successive ticks.
REQ-033 mode_valid coinciding with a tick, and two requests (2 then 3) between ticks -> the bypass applies in the same edge with pending_o never set; in the two-request case mode 3 is applied and mode 2 is never visible.
REQ-034 pause high for 10 cycles mid-step, then RST_N pulsed low for 1 cycle mid-step -> LEDG and the count freeze during pause and the step resumes its remaining cycles after pause falls; the reset drives all outputs to reset values asynchronously and the first tick falls 4 cycles after release.
